// File: rtl/leg_pkg.sv
// Shared types and constants for the LEG instruction encoder.
package leg_pkg;

    typedef enum logic [1:0] {
        CLS_CALC = 2'd0,
        CLS_JUMP = 2'd1,
        CLS_RAW  = 2'd2,
        CLS_RSV  = 2'd3
    } instr_class_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } enc_state_t;

    localparam int         IMM1_BIT      = 7;
    localparam int         IMM2_BIT      = 6;
    localparam logic [7:0] JUMP_BASE     = 8'h20;
    localparam logic [2:0] JUMP_MAX_COND = 3'd5;
    localparam int         INSTR_BYTES   = 4;

endpackage

// File: rtl/leg_opcode_pack.sv
// Combinational packing of instruction fields into a LEG opcode byte,
// flagging field combinations the decoder could not interpret.
module leg_opcode_pack
    import leg_pkg::*;
#(
    parameter bit REJECT_JUMP_IMM = 1'b1
) (
    input  logic [1:0] cls,
    input  logic       imm1,
    input  logic       imm2,
    input  logic [5:0] op,
    output logic [7:0] opcode,
    output logic       illegal
);

    logic [5:0] body;

    // Build the 6-bit opcode body per class, then place the immediate flags on top
    always_comb begin
        body    = 6'd0;
        illegal = 1'b0;
        case (instr_class_t'(cls))
            CLS_CALC: body = {2'b00, op[3:0]};
            CLS_JUMP: begin
                body = JUMP_BASE[5:0] + {3'b000, op[2:0]};
                if (op[2:0] > JUMP_MAX_COND) illegal = 1'b1;
                if (REJECT_JUMP_IMM && (imm1 || imm2)) illegal = 1'b1;
            end
            CLS_RAW:  body = op;
            default:  illegal = 1'b1;
        endcase
        opcode           = {2'b00, body};
        opcode[IMM1_BIT] = imm1;
        opcode[IMM2_BIT] = imm2;
    end

endmodule

// File: rtl/leg_instr_encoder.sv
// LEG instruction encoder: accepts instruction fields, packs the opcode and
// streams the four instruction bytes into program memory through a stallable port.
module leg_instr_encoder
    import leg_pkg::*;
#(
    parameter int ADDR_W          = 8,
    parameter int CNT_W           = 16,
    parameter bit REJECT_JUMP_IMM = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic              in_imm1,
    input  logic              in_imm2,
    input  logic [5:0]        in_op,
    input  logic [7:0]        in_arg1,
    input  logic [7:0]        in_arg2,
    input  logic [7:0]        in_dest,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  instr_count
);

    enc_state_t state;
    enc_state_t next_state;

    logic [7:0] pack_opcode;
    logic       pack_illegal;

    logic [INSTR_BYTES-1:0][7:0] instr_q;
    logic [1:0]                  byte_idx;

    logic accept;
    logic byte_done;
    logic last_byte;

    leg_opcode_pack #(
        .REJECT_JUMP_IMM(REJECT_JUMP_IMM)
    ) u_pack (
        .cls     (in_class),
        .imm1    (in_imm1),
        .imm2    (in_imm2),
        .op      (in_op),
        .opcode  (pack_opcode),
        .illegal (pack_illegal)
    );

    assign accept    = in_valid && in_ready;
    assign byte_done = mem_we && mem_ready;
    assign last_byte = byte_done && (byte_idx == 2'(INSTR_BYTES - 1));

    // State register; reset aborts any instruction being emitted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Enter EMIT on a legal accept, return to IDLE once the last byte is taken
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept && !pack_illegal) next_state = ST_EMIT;
            ST_EMIT: if (last_byte)               next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake and write-port outputs decoded from the current state and byte index
    always_comb begin
        in_ready  = (state == ST_IDLE);
        busy      = (state == ST_EMIT);
        mem_we    = (state == ST_EMIT);
        mem_wdata = (state == ST_EMIT) ? instr_q[byte_idx] : 8'd0;
    end

    // Field latch, byte index, write address, error pulse and completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q     <= '0;
            byte_idx    <= 2'd0;
            mem_addr    <= '0;
            err         <= 1'b0;
            instr_count <= '0;
        end else begin
            err <= accept && pack_illegal;
            if (state == ST_IDLE) begin
                if (load_valid) mem_addr <= load_addr;
                if (accept && !pack_illegal) begin
                    instr_q  <= {in_dest, in_arg2, in_arg1, pack_opcode};
                    byte_idx <= 2'd0;
                end
            end else if (byte_done) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                byte_idx <= byte_idx + 2'd1;
                if (last_byte) instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule
